// File: rtl/tx_serial_arbitro.sv
// Round-robin arbiter sharing one 7N2 serial transmitter between 4 requesters.
// Optional ESPERA watchdog with sticky erro flag: define TX_TIMEOUT_EN.
module tx_serial_arbitro #(
    parameter int TIMEOUT_CICLOS = 8192,
    parameter int TW             = 14
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  pedido,
    input  logic [27:0] dados,
    output logic [3:0]  ack,
    output logic        tx_partida,
    output logic [6:0]  tx_dados,
    input  logic        tx_pronto,
    output logic        ocupado,
    output logic        erro,
    output logic [3:0]  db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        PARTIDA = 3'd1,
        ESPERA  = 3'd2,
        FIM     = 3'd3,
        ABORTA  = 3'd4
    } estado_t;

    estado_t    estado_q, estado_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] venc_q, venc_d;
    logic [6:0] tx_dados_q, tx_dados_d;
    logic [1:0] cand;
    logic [1:0] idx;
    logic       achou;

    // First requesting bit scanning ptr, ptr+1, ... with 2-bit wraparound
    always_comb begin
        cand  = ptr_q;
        achou = 1'b0;
        idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!achou && pedido[idx]) begin
                cand  = idx;
                achou = 1'b1;
            end
        end
    end

`ifdef TX_TIMEOUT_EN
    logic [TW-1:0] cnt_q, cnt_d;
    logic          erro_q, erro_d;
    logic          limite;

    assign limite = (cnt_q == TW'(TIMEOUT_CICLOS - 1));

    always_comb begin
        cnt_d  = cnt_q;
        erro_d = erro_q;
        if (estado_q == PARTIDA) begin
            cnt_d = '0;
        end else if (estado_q == ESPERA) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (estado_q == ABORTA) begin
            erro_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            erro_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            erro_q <= erro_d;
        end
    end

    assign erro = erro_q;
`else
    assign erro = 1'b0;
`endif

    always_comb begin
        estado_d   = estado_q;
        ptr_d      = ptr_q;
        venc_d     = venc_q;
        tx_dados_d = tx_dados_q;
        ack        = '0;
        tx_partida = 1'b0;
        ocupado    = (estado_q != OCIOSO);
        case (estado_q)
            OCIOSO: begin
                if (|pedido) begin
                    venc_d     = cand;
                    tx_dados_d = dados[7*int'(cand) +: 7];
                    estado_d   = PARTIDA;
                end
            end
            PARTIDA: begin
                tx_partida = 1'b1;
                estado_d   = ESPERA;
            end
            ESPERA: begin
                // pronto on the limit cycle still completes the frame
                if (tx_pronto) begin
                    estado_d = FIM;
`ifdef TX_TIMEOUT_EN
                end else if (limite) begin
                    estado_d = ABORTA;
`endif
                end
            end
            FIM: begin
                ack      = 4'b0001 << venc_q;
                ptr_d    = venc_q + 2'd1;
                estado_d = OCIOSO;
            end
`ifdef TX_TIMEOUT_EN
            ABORTA: begin
                ptr_d    = venc_q + 2'd1;
                estado_d = OCIOSO;
            end
`endif
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            ptr_q      <= '0;
            venc_q     <= '0;
            tx_dados_q <= '0;
        end else begin
            estado_q   <= estado_d;
            ptr_q      <= ptr_d;
            venc_q     <= venc_d;
            tx_dados_q <= tx_dados_d;
        end
    end

    assign tx_dados  = tx_dados_q;
    assign db_estado = {1'b0, estado_q};

endmodule

// File: tb/tb_tx_serial_arbitro.sv
// Self-checking bench for tx_serial_arbitro: vector table, fairness run,
// randomized traffic against a transaction-level model, optional timeout.
module tb_tx_serial_arbitro;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  pedido;
    logic [27:0] dados;
    logic [3:0]  ack;
    logic        tx_partida;
    logic [6:0]  tx_dados;
    logic        tx_pronto;
    logic        ocupado;
    logic        erro;
    logic [3:0]  db_estado;

    always #5 clock = ~clock;

    tx_serial_arbitro #(
        .TIMEOUT_CICLOS(16),
        .TW(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pedido(pedido),
        .dados(dados),
        .ack(ack),
        .tx_partida(tx_partida),
        .tx_dados(tx_dados),
        .tx_pronto(tx_pronto),
        .ocupado(ocupado),
        .erro(erro),
        .db_estado(db_estado)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nome, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nome, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [27:0] pk(input logic [6:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    typedef struct {
        logic        rst;
        logic [3:0]  ped;
        logic [27:0] d;
        logic        pr;
        logic [3:0]  e_st;
        logic [3:0]  e_ack;
        logic        e_part;
        logic [6:0]  e_txd;
        logic        e_oc;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] ped,
                                input logic [27:0] d, input logic pr,
                                input logic [3:0] st, input logic [3:0] ak,
                                input logic pt, input logic [6:0] txd,
                                input logic oc);
        vec_t v;
        v.rst = rst; v.ped = ped; v.d = d; v.pr = pr;
        v.e_st = st; v.e_ack = ak; v.e_part = pt; v.e_txd = txd; v.e_oc = oc;
        return v;
    endfunction

    vec_t tab[$];

    // random-phase model state
    logic [3:0] pend;
    logic [6:0] ch [4];
    logic [6:0] latched;
    int         wait_cnt [4];
    bit         busy;
    int         win, t_part, t_pr, free_at, mptr, ack_cyc, ack_win;
    logic [3:0] ped_drv;
    logic [27:0] d_drv;
    logic       pr_drv;

    initial begin
        reset = 1'b1; pedido = '0; dados = '0; tx_pronto = 1'b0;

        // inputs for one cycle, then expected outputs after the edge
        tab.push_back(mk(1, 4'h0, pk(0,0,0,0), 0,          0, 4'h0, 0, 7'h00, 0));
        tab.push_back(mk(0, 4'h1, pk(7'h41,0,0,0), 0,      1, 4'h0, 1, 7'h41, 1));
        tab.push_back(mk(0, 4'h1, pk(7'h41,0,0,0), 0,      2, 4'h0, 0, 7'h41, 1));
        tab.push_back(mk(0, 4'h0, pk(7'h5A,0,0,0), 0,      2, 4'h0, 0, 7'h41, 1));
        tab.push_back(mk(0, 4'h0, pk(7'h5A,0,0,0), 1,      3, 4'h1, 0, 7'h41, 1));
        tab.push_back(mk(0, 4'h0, pk(7'h5A,0,0,0), 0,      0, 4'h0, 0, 7'h41, 0));
        tab.push_back(mk(0, 4'h0, pk(7'h5A,0,0,0), 1,      0, 4'h0, 0, 7'h41, 0));
        tab.push_back(mk(0, 4'h4, pk(7'h5A,0,7'h33,0), 0,  1, 4'h0, 1, 7'h33, 1));
        tab.push_back(mk(0, 4'h4, pk(7'h5A,0,7'h33,0), 1,  2, 4'h0, 0, 7'h33, 1));
        tab.push_back(mk(0, 4'h4, pk(7'h5A,0,7'h33,0), 0,  2, 4'h0, 0, 7'h33, 1));
        tab.push_back(mk(0, 4'h4, pk(7'h5A,0,7'h33,0), 1,  3, 4'h4, 0, 7'h33, 1));
        tab.push_back(mk(0, 4'h5, pk(7'h30,0,7'h32,0), 0,  0, 4'h0, 0, 7'h33, 0));
        tab.push_back(mk(0, 4'h5, pk(7'h30,0,7'h32,0), 0,  1, 4'h0, 1, 7'h30, 1));
        tab.push_back(mk(0, 4'h5, pk(7'h30,0,7'h32,0), 0,  2, 4'h0, 0, 7'h30, 1));
        tab.push_back(mk(0, 4'h5, pk(7'h30,0,7'h32,0), 1,  3, 4'h1, 0, 7'h30, 1));
        tab.push_back(mk(0, 4'h4, pk(7'h30,0,7'h32,0), 0,  0, 4'h0, 0, 7'h30, 0));
        tab.push_back(mk(0, 4'h4, pk(7'h30,0,7'h32,0), 0,  1, 4'h0, 1, 7'h32, 1));
        tab.push_back(mk(0, 4'h4, pk(7'h30,0,7'h32,0), 0,  2, 4'h0, 0, 7'h32, 1));
        tab.push_back(mk(1, 4'h4, pk(7'h30,0,7'h32,0), 0,  0, 4'h0, 0, 7'h00, 0));
        tab.push_back(mk(0, 4'h4, pk(7'h30,0,7'h32,0), 0,  1, 4'h0, 1, 7'h32, 1));
        tab.push_back(mk(0, 4'h0, pk(7'h30,0,7'h32,0), 0,  2, 4'h0, 0, 7'h32, 1));
        tab.push_back(mk(0, 4'h0, pk(7'h30,0,7'h32,0), 1,  3, 4'h4, 0, 7'h32, 1));
        tab.push_back(mk(0, 4'h0, pk(7'h30,0,7'h32,0), 0,  0, 4'h0, 0, 7'h32, 0));

        tick;
        for (int k = 0; k < tab.size(); k++) begin
            reset = tab[k].rst; pedido = tab[k].ped;
            dados = tab[k].d;   tx_pronto = tab[k].pr;
            tick;
            chk($sformatf("vec%0d estado", k), 32'(db_estado), 32'(tab[k].e_st));
            chk($sformatf("vec%0d ack", k), 32'(ack), 32'(tab[k].e_ack));
            chk($sformatf("vec%0d partida", k), 32'(tx_partida), 32'(tab[k].e_part));
            chk($sformatf("vec%0d tx_dados", k), 32'(tx_dados), 32'(tab[k].e_txd));
            chk($sformatf("vec%0d ocupado", k), 32'(ocupado), 32'(tab[k].e_oc));
            chk($sformatf("vec%0d erro", k), 32'(erro), 32'd0);
        end

        // all four requesting: grants 0,1,2,3, each ack a single pulse
        reset = 1'b1; tx_pronto = 1'b0; pedido = '0;
        tick;
        reset = 1'b0; pedido = 4'hF;
        dados = pk(7'h30, 7'h31, 7'h32, 7'h33);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("rr%0d partida", k), 32'(tx_partida), 32'd1);
            chk($sformatf("rr%0d tx_dados", k), 32'(tx_dados), 32'h30 + 32'(k));
            tick;
            tx_pronto = 1'b1;
            tick;
            chk($sformatf("rr%0d ack", k), 32'(ack), 32'(4'b0001 << k));
            tx_pronto = 1'b0;
            pedido[k] = 1'b0;
            tick;
            chk($sformatf("rr%0d ack_pulse", k), 32'(ack), 32'd0);
            chk($sformatf("rr%0d ocioso", k), 32'(db_estado), 32'd0);
        end

        // randomized traffic vs transaction-level model
        reset = 1'b1; pedido = '0; tx_pronto = 1'b0;
        tick;
        reset = 1'b0;
        pend = '0; busy = 0; free_at = 0; mptr = 0;
        ack_cyc = -10; ack_win = 0; win = 0; t_part = -10; t_pr = -10;
        latched = '0;
        for (int i = 0; i < 4; i++) begin
            ch[i] = '0;
            wait_cnt[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && !(cyc == ack_cyc && i == ack_win) &&
                    $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    ch[i] = 7'($urandom);
                end
            end
            if (!busy && cyc >= free_at && pend != 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (pend[(mptr + k) % 4]) begin
                        win = (mptr + k) % 4;
                        break;
                    end
                end
                chk("rand fairness", 32'(wait_cnt[win]), 32'(wait_cnt[win] > 3 ? 3 : wait_cnt[win]));
                for (int i = 0; i < 4; i++)
                    if (pend[i] && i != win) wait_cnt[i]++;
                wait_cnt[win] = 0;
                busy = 1;
                t_part = cyc + 1;
                t_pr = cyc + 2 + int'($urandom_range(0, 5));
                latched = ch[win];
            end
            ped_drv = pend;
            d_drv = {ch[3], ch[2], ch[1], ch[0]};
            pr_drv = 1'b0;
            if (busy && cyc >= t_part) begin
                d_drv[7*win +: 7] = 7'($urandom);
                if ($urandom_range(0, 2) == 0) ped_drv[win] = 1'b0;
            end
            if (busy && cyc == t_pr) pr_drv = 1'b1;
            if (busy && cyc == t_part && $urandom_range(0, 1) == 0) pr_drv = 1'b1;
            if (!busy && cyc >= free_at && $urandom_range(0, 3) == 0) pr_drv = 1'b1;
            pedido = ped_drv; dados = d_drv; tx_pronto = pr_drv;
            tick;
            chk("rand partida", 32'(tx_partida), 32'(busy && cyc + 1 == t_part));
            chk("rand ack", 32'(ack),
                (busy && cyc + 1 == t_pr + 1) ? 32'(4'b0001 << win) : 32'd0);
            chk("rand ocupado", 32'(ocupado), 32'(busy));
            if (busy) chk("rand tx_dados", 32'(tx_dados), 32'(latched));
            if (busy && cyc + 1 == t_pr + 1) begin
                pend[win] = 1'b0;
                busy = 0;
                free_at = t_pr + 2;
                mptr = (win + 1) % 4;
                ack_cyc = cyc + 1;
                ack_win = win;
            end
        end

`ifdef TX_TIMEOUT_EN
        // watchdog: 16 ESPERA cycles then ABORTA, erro sticky, no ack
        reset = 1'b1; pedido = '0; tx_pronto = 1'b0;
        tick;
        reset = 1'b0; pedido = 4'h1; dados = pk(7'h41, 7'h42, 0, 0);
        tick;
        chk("to partida", 32'(tx_partida), 32'd1);
        for (int k = 0; k < 16; k++) begin
            tick;
            chk($sformatf("to espera%0d", k), 32'(db_estado), 32'd2);
        end
        tick;
        chk("to aborta", 32'(db_estado), 32'd4);
        chk("to aborta ack", 32'(ack), 32'd0);
        chk("to aborta ocupado", 32'(ocupado), 32'd1);
        pedido = 4'h2;
        tick;
        chk("to ocioso", 32'(db_estado), 32'd0);
        chk("to erro", 32'(erro), 32'd1);
        chk("to ocupado", 32'(ocupado), 32'd0);
        chk("to ack", 32'(ack), 32'd0);
        tick;
        chk("to next partida", 32'(tx_partida), 32'd1);
        chk("to next tx_dados", 32'(tx_dados), 32'h42);
        tick;
        tx_pronto = 1'b1;
        tick;
        chk("to next ack", 32'(ack), 32'h2);
        chk("to erro sticky", 32'(erro), 32'd1);
        tx_pronto = 1'b0; pedido = '0;
        tick;
        reset = 1'b1;
        tick;
        chk("to erro reset", 32'(erro), 32'd0);
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tx_serial_arbitro.md
Name: tx_serial_arbitro

Overview:
- Round-robin arbiter and sequencer that shares one 7N2 serial transmitter (115200 baud tick, partida/pronto handshake) between 4 requesters.
- Picks one requester and latches its 7-bit ASCII character. Pulses the transmitter start, waits for end-of-frame, then acknowledges the winner.
- Sits between the producers (keyboard/ROM/status sources) and the transmitter's partida/dados_ascii/pronto pins.

Parameters:
- TIMEOUT_CICLOS, 8192, cycles allowed in ESPERA before abort (one 7N2 frame = 10 bits x 434 = 4340 cycles); used only with TX_TIMEOUT_EN.
- TW, 14, width of timeout counter; must satisfy 2^TW > TIMEOUT_CICLOS.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- pedido  in  4  request lines; bit i = requester i; level, held until its ack.
- dados  in  28  character inputs; dados[7i+6:7i] = ASCII of requester i.
- ack  out  4  one-cycle pulse on bit i when requester i's frame has finished.
- tx_partida  out  1  one-cycle start pulse to the transmitter.
- tx_dados  out  7  registered character to the transmitter's dados_ascii.
- tx_pronto  in  1  one-cycle end-of-frame pulse from the transmitter.
- ocupado  out  1  high from grant until ack inclusive.
- erro  out  1  sticky timeout flag (TX_TIMEOUT_EN only; tied 0 otherwise).
- db_estado  out  4  state code for a hexa7seg display.

Behaviour:
- Clock and reset: one clock `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - state=OCIOSO, ack=0, tx_partida=0, tx_dados=0, ocupado=0, erro=0.
  - Pointer ptr=0, winner register=0, timeout counter=0.
  - Reset overrides everything, including mid-frame. An interrupted frame is never acked.
- State encoding (db_estado): OCIOSO=0, PARTIDA=1, ESPERA=2, FIM=3, ABORTA=4. Any other encoding goes to OCIOSO.
- OCIOSO:
  - If pedido!=0, select the first set bit scanning ptr, ptr+1, ... mod 4.
  - Register winner, set tx_dados=dados[winner], set ocupado=1, go to PARTIDA.
  - Otherwise stay. tx_pronto is ignored here.
- PARTIDA: tx_partida=1 for exactly this cycle; clear timeout counter; go to ESPERA.
- ESPERA:
  - Wait for tx_pronto=1, then go to FIM.
  - tx_dados is held constant for the whole state; later changes on dados or pedido have no effect.
  - Deasserting the winner's pedido does not cancel the frame.
- FIM:
  - ack[winner]=1 for this cycle only.
  - ptr <= (winner+1) mod 4.
  - ocupado=1 in this cycle, 0 from the next.
  - Go to OCIOSO.
- ABORTA: see Optional Feature. No ack; ptr <= (winner+1) mod 4; go to OCIOSO.
- Latency:
  - pedido seen in OCIOSO at cycle t: tx_partida at t+1.
  - tx_pronto at cycle p: ack at p+1, back in OCIOSO at p+2.
  - Earliest next tx_partida is p+3, which guarantees a low gap on partida for the transmitter's edge detector.
- Fairness: with all 4 requesting continuously, grants are 0,1,2,3,0,... No requester waits more than 3 frames.
- Simultaneous events:
  - tx_pronto coinciding with PARTIDA is ignored; only pronto seen in ESPERA counts.
  - pedido bits that change on the grant cycle are sampled as-is on that edge.
- A requester must drop pedido within 1 cycle after its ack or it is re-arbitrated. It then competes normally under round-robin.

Optional Feature:
- Macro: TX_TIMEOUT_EN.
- Defined:
  - In ESPERA, the counter increments each cycle.
  - If it reaches TIMEOUT_CICLOS-1 without tx_pronto, go to ABORTA.
  - In ABORTA: erro <= 1 (sticky until reset), ack stays 0, ocupado clears the next cycle.
  - tx_pronto arriving on the same cycle as the limit wins: go to FIM, no error.
- Not defined: no counter and no ABORTA state. ESPERA waits indefinitely; erro is constant 0.

Test Plan:
- Reset then pedido=0001, dados[6:0]=0x41 at t: tx_partida=1 at t+1, tx_dados=0x41. Pulse tx_pronto at t+50: ack=0001 at t+51, ocupado=0 at t+52.
- pedido=1111 held, dados = 0x30,0x31,0x32,0x33, each requester drops pedido one cycle after its own ack: grant order 0,1,2,3. tx_dados sequence 0x30..0x33. Each ack a single pulse.
- After serving requester 2, pedido=0101: next grant is 0 (ptr=3 wraps), then 2.
- Change dados[6:0] to 0x5A during ESPERA: tx_dados stays 0x41. Drop pedido[0] mid-frame: ack[0] still pulses after tx_pronto.
- Assert reset in ESPERA: next cycle state=0, ocupado=0, tx_dados=0, no ack ever issued. A subsequent request starts normally.
- TX_TIMEOUT_EN with TIMEOUT_CICLOS=16, never pulse tx_pronto: ABORTA after 16 ESPERA cycles, erro=1 sticky, ack=0000. Next requester is served normally.
